// File: rtl/acoustic_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer and the
// capture-buffer slave. Only the signals this master actually uses are carried.
interface acoustic_burst_writer_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
   logic [7:0]            M_AXI_AWLEN;
   logic [2:0]            M_AXI_AWSIZE;
   logic [1:0]            M_AXI_AWBURST;
   logic                  M_AXI_AWVALID;
   logic                  M_AXI_AWREADY;
   logic [31:0]           M_AXI_WDATA;
   logic [3:0]            M_AXI_WSTRB;
   logic                  M_AXI_WLAST;
   logic                  M_AXI_WVALID;
   logic                  M_AXI_WREADY;
   logic [1:0]            M_AXI_BRESP;
   logic                  M_AXI_BVALID;
   logic                  M_AXI_BREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY
   );
endinterface

// File: rtl/acoustic_burst_writer.sv
// Hydrophone capture writer: buffers the free-running ADC stream in a small
// FIFO and drains it as fixed-length INCR bursts into a circular buffer.
// Samples arriving while the FIFO is full are dropped and flagged.
module acoustic_burst_writer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int BURST_BEATS = 8,
   parameter int BUF_BYTES   = 4096
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [31:0]           s_tdata,
   input  logic                  s_tvalid,
   acoustic_burst_writer_if.master m_axi,
   output logic [31:0]           burst_count,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic                  overflow,
   output logic                  bresp_err
);

   localparam int PTR_W       = $clog2(FIFO_DEPTH);
   localparam int CNT_W       = PTR_W + 1;
   localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam int BURST_BYTES = BURST_BEATS * 4;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [31:0]           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_idx_q;
   logic [PTR_W-1:0]      wr_idx_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic                  overflow_q;
   logic                  fifo_full;
   logic                  fifo_push;
   logic                  fifo_pop;

   // Burst engine registers
   state_t                state_q;
   logic                  awvalid_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic                  wvalid_q;
   logic                  wlast_q;
   logic                  bready_q;
   logic [BEAT_W-1:0]     beat_q;
   logic [31:0]           burst_count_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic                  bresp_err_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_inc;
   logic [ADDR_WIDTH-1:0] buf_end;

   // A pop frees a slot in the same cycle, so a push while full still lands
   // when the head is leaving; the slot written is never the head otherwise.
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_pop   = wvalid_q & m_axi.M_AXI_WREADY;
   assign fifo_push  = s_tvalid & (~fifo_full | fifo_pop);
   assign wr_ptr_inc = wr_ptr_q + ADDR_WIDTH'(BURST_BYTES);
   assign buf_end    = base_q + ADDR_WIDTH'(BUF_BYTES);

   // Occupancy next-state from the push/pop pair
   always_comb begin
      count_d = count_q;
      case ({fifo_push, fifo_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Sample storage; contents need no reset because occupancy gates every read
   always_ff @(posedge ACLK) begin
      if (fifo_push) begin
         mem_q[wr_idx_q] <= s_tdata;
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rd_idx_q   <= '0;
         wr_idx_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_push) begin
            wr_idx_q <= wr_idx_q + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_idx_q <= rd_idx_q + PTR_W'(1);
         end
         count_q <= count_d;
         if (s_tvalid && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Burst sequencer: one outstanding transaction, AW then W then B, all outputs registered
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q       <= ST_IDLE;
         awvalid_q     <= 1'b0;
         awaddr_q      <= base_addr;
         wvalid_q      <= 1'b0;
         wlast_q       <= 1'b0;
         bready_q      <= 1'b0;
         beat_q        <= '0;
         burst_count_q <= 32'd0;
         wr_ptr_q      <= base_addr;
         base_q        <= base_addr;
         bresp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && (count_q >= CNT_W'(BURST_BEATS))) begin
                  awaddr_q  <= wr_ptr_q;
                  awvalid_q <= 1'b1;
                  state_q   <= ST_ADDR;
               end else if (!enable) begin
                  // While stopped, track the base so a restart begins at its start
                  wr_ptr_q <= base_addr;
                  base_q   <= base_addr;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (m_axi.M_AXI_AWREADY) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  beat_q    <= '0;
                  wlast_q   <= (LAST_BEAT == BEAT_W'(0));
                  state_q   <= ST_DATA;
               end else begin
                  state_q <= ST_ADDR;
               end
            end
            ST_DATA: begin
               if (m_axi.M_AXI_WREADY) begin
                  if (beat_q == LAST_BEAT) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     bready_q <= 1'b1;
                     state_q  <= ST_RESP;
                  end else begin
                     beat_q  <= beat_q + BEAT_W'(1);
                     wlast_q <= ((beat_q + BEAT_W'(1)) == LAST_BEAT);
                  end
               end else begin
                  state_q <= ST_DATA;
               end
            end
            ST_RESP: begin
               if (m_axi.M_AXI_BVALID) begin
                  bready_q      <= 1'b0;
                  burst_count_q <= burst_count_q + 32'd1;
                  if (m_axi.M_AXI_BRESP != 2'b00) begin
                     bresp_err_q <= 1'b1;
                  end
                  wr_ptr_q <= (wr_ptr_inc == buf_end) ? base_q : wr_ptr_inc;
                  state_q  <= ST_IDLE;
               end else begin
                  state_q <= ST_RESP;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               awvalid_q <= 1'b0;
               wvalid_q  <= 1'b0;
               wlast_q   <= 1'b0;
               bready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_axi.M_AXI_AWADDR  = awaddr_q;
   assign m_axi.M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
   assign m_axi.M_AXI_AWSIZE  = 3'b010;
   assign m_axi.M_AXI_AWBURST = 2'b01;
   assign m_axi.M_AXI_AWVALID = awvalid_q;
   assign m_axi.M_AXI_WDATA   = mem_q[rd_idx_q];
   assign m_axi.M_AXI_WSTRB   = 4'hF;
   assign m_axi.M_AXI_WLAST   = wlast_q;
   assign m_axi.M_AXI_WVALID  = wvalid_q;
   assign m_axi.M_AXI_BREADY  = bready_q;

   assign burst_count = burst_count_q;
   assign wr_ptr      = wr_ptr_q;
   assign overflow    = overflow_q;
   assign bresp_err   = bresp_err_q;

endmodule

// File: tb/tb_acoustic_burst_writer.sv
// Randomized bench for acoustic_burst_writer: a stimulus process feeds ADC
// samples, a slave process answers the AXI channels, and a scoreboard process
// keeps a queue-based model of accepted samples and burst addresses.
module tb_acoustic_burst_writer;

   localparam int FIFO_DEPTH = 16;
   localparam int BUF_BYTES  = 4096;
   localparam int SEGMENTS   = BUF_BYTES / 32;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        enable;
   logic [31:0] base_addr;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic [31:0] burst_count;
   logic [31:0] wr_ptr;
   logic        overflow;
   logic        bresp_err;

   acoustic_burst_writer_if #(.ADDR_WIDTH(32)) bus ();

   acoustic_burst_writer #(
      .ADDR_WIDTH(32), .FIFO_DEPTH(FIFO_DEPTH), .BURST_BEATS(8), .BUF_BYTES(BUF_BYTES)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .base_addr(base_addr),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .m_axi(bus),
      .burst_count(burst_count), .wr_ptr(wr_ptr), .overflow(overflow), .bresp_err(bresp_err)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp  = 0;
   int n_fail = 0;

   // slave behaviour knobs
   int aw_stall    = 0;
   bit wready_rand = 1'b0;
   int err_burst   = 0;

   // reference model state
   logic [31:0] model_q[$];
   logic [31:0] base_m   = 32'd0;
   int          seg      = 0;
   int          sb_beat  = 0;
   bit          exp_ovf  = 1'b0;
   bit          exp_err  = 1'b0;
   logic [31:0] exp_bc   = 32'd0;
   bit          rst_chk  = 1'b0;
   bit          aw_hold  = 1'b0;
   bit          w_hold   = 1'b0;
   bit          wp_chk   = 1'b0;
   logic [31:0] aw_held;
   logic [31:0] w_held;
   logic        w_held_last;
   logic [31:0] seq = 32'd1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: compare outputs registered at the last edge, then fold in
   // the events the upcoming edge will see.
   initial begin : scoreboard
      logic [31:0] exp_d;
      forever begin
         @(negedge ACLK);
         if (rst_chk) begin
            check("reset_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_WLAST}, 4'b0000);
            check("reset_wr_ptr", wr_ptr, base_m);
            check("reset_awaddr", bus.M_AXI_AWADDR, base_m);
            rst_chk = 1'b0;
         end
         check("burst_count", burst_count, exp_bc);
         check("overflow", overflow, exp_ovf);
         check("bresp_err", bresp_err, exp_err);
         check("aw_w_overlap", bus.M_AXI_AWVALID & bus.M_AXI_WVALID, 1'b0);
         if (aw_hold) begin
            check("aw_stable", {bus.M_AXI_AWVALID, bus.M_AXI_AWADDR}, {1'b1, aw_held});
         end
         if (w_hold) begin
            check("w_stable", {bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_WDATA}, {1'b1, w_held_last, w_held});
         end
         if (wp_chk) begin
            check("wr_ptr_after_b", wr_ptr, base_m + 32'(seg * 32));
            wp_chk = 1'b0;
         end

         if (ARESET) begin
            model_q.delete();
            base_m  = base_addr;
            seg     = 0;
            sb_beat = 0;
            exp_ovf = 1'b0;
            exp_err = 1'b0;
            exp_bc  = 32'd0;
            aw_hold = 1'b0;
            w_hold  = 1'b0;
            wp_chk  = 1'b0;
            rst_chk = 1'b1;
         end else begin
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
               check("aw_addr", bus.M_AXI_AWADDR, base_m + 32'(seg * 32));
               check("aw_shape", {bus.M_AXI_AWLEN, bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST}, {8'd7, 3'b010, 2'b01});
               check("aw_words_buffered", model_q.size() >= 8, 1'b1);
            end
            aw_hold = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
            aw_held = bus.M_AXI_AWADDR;

            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
               exp_d = 'x;
               if (model_q.size() > 0) exp_d = model_q.pop_front();
               check("w_data", bus.M_AXI_WDATA, exp_d);
               check("w_last", bus.M_AXI_WLAST, sb_beat == 7);
               check("w_strb", bus.M_AXI_WSTRB, 4'hF);
               sb_beat = (sb_beat == 7) ? 0 : sb_beat + 1;
            end
            w_hold      = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
            w_held      = bus.M_AXI_WDATA;
            w_held_last = bus.M_AXI_WLAST;

            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
               exp_bc = exp_bc + 32'd1;
               if (bus.M_AXI_BRESP != 2'b00) exp_err = 1'b1;
               seg    = (seg + 1) % SEGMENTS;
               wp_chk = 1'b1;
            end

            // free-running input: kept if a slot is free after this cycle's pop
            if (s_tvalid) begin
               if (model_q.size() < FIFO_DEPTH) model_q.push_back(s_tdata);
               else exp_ovf = 1'b1;
            end
         end
      end
   end

   // AXI slave: optional AWREADY stall, optional random WREADY, delayed B response
   initial begin : slave
      int aw_wait;
      bit bv;
      logic [1:0] br;
      bit b_pend;
      int b_dly;
      int bidx;
      aw_wait = 0; bv = 1'b0; br = 2'b00; b_pend = 1'b0; b_dly = 0; bidx = 0;
      bus.M_AXI_AWREADY = 1'b0;
      bus.M_AXI_WREADY  = 1'b0;
      bus.M_AXI_BVALID  = 1'b0;
      bus.M_AXI_BRESP   = 2'b00;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            aw_wait = 0; bv = 1'b0; b_pend = 1'b0; bidx = 0;
         end else begin
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) aw_wait = 0;
            else if (bus.M_AXI_AWVALID) aw_wait++;
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY && bus.M_AXI_WLAST) begin
               b_pend = 1'b1;
               b_dly  = $urandom_range(2, 0);
               bidx++;
            end
            if (bv && bus.M_AXI_BREADY) bv = 1'b0;
            if (b_pend && !bv) begin
               if (b_dly == 0) begin
                  bv     = 1'b1;
                  br     = (bidx == err_burst) ? 2'b10 : 2'b00;
                  b_pend = 1'b0;
               end else begin
                  b_dly--;
               end
            end
         end
         @(posedge ACLK);
         #1;
         bus.M_AXI_AWREADY = (aw_stall == 0) || (aw_wait >= aw_stall);
         bus.M_AXI_WREADY  = wready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
         bus.M_AXI_BVALID  = bv;
         bus.M_AXI_BRESP   = br;
      end
   end

   task automatic do_reset(input logic [31:0] b);
      @(posedge ACLK);
      #1;
      ARESET    = 1'b1;
      base_addr = b;
      s_tvalid  = 1'b0;
      seq       = 32'd1;
      repeat (3) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
   endtask

   task automatic feed(input int n, input int pct);
      int sent = 0;
      while (sent < n) begin
         @(posedge ACLK);
         #1;
         if (int'($urandom_range(99, 0)) < pct) begin
            s_tvalid = 1'b1;
            s_tdata  = seq;
            seq      = seq + 32'd1;
            sent++;
         end else begin
            s_tvalid = 1'b0;
         end
      end
      @(posedge ACLK);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_bc(input logic [31:0] target, input int budget);
      int k = 0;
      while (burst_count !== target && k < budget) begin
         @(negedge ACLK);
         k++;
      end
      check("wait_burst_count", burst_count, target);
   endtask

   // Stimulus sequence
   initial begin : stimulus
      int k;
      ARESET = 1'b1; enable = 1'b1; base_addr = 32'd0; s_tdata = 32'd0; s_tvalid = 1'b0;

      // single burst of samples 1..8 at base 0
      do_reset(32'h0000_0000);
      feed(8, 100);
      wait_bc(32'd1, 100);
      check("p1_wr_ptr", wr_ptr, 32'h0000_0020);

      // 128 samples from base 0x1000, then a long stream that wraps the buffer
      do_reset(32'h0000_1000);
      feed(128, 40);
      wait_bc(32'd16, 500);
      check("p2_wr_ptr", wr_ptr, 32'h0000_1200);
      feed(1024, 40);
      wait_bc(32'd144, 500);
      check("p3_wr_ptr_wrapped", wr_ptr, 32'h0000_1200);
      check("p3_no_overflow", overflow, 1'b0);

      // AW stall of 20 cycles, random WREADY, sample every cycle
      aw_stall = 20; wready_rand = 1'b1;
      do_reset(32'h0000_0000);
      feed(60, 100);
      repeat (400) @(negedge ACLK);
      check("p4_overflow_sticky", overflow, 1'b1);
      aw_stall = 0; wready_rand = 1'b0;

      // SLVERR on the second burst
      err_burst = 2;
      do_reset(32'h0000_2000);
      feed(32, 40);
      wait_bc(32'd4, 300);
      check("p5_bresp_err", bresp_err, 1'b1);
      err_burst = 0;
      feed(8, 100);
      wait_bc(32'd5, 100);
      check("p5_bresp_err_sticky", bresp_err, 1'b1);
      check("p5_wr_ptr", wr_ptr, 32'h0000_20A0);

      // reset in the middle of a burst
      do_reset(32'h0000_3000);
      feed(12, 100);
      k = 0;
      while (sb_beat != 4 && k < 200) begin
         @(posedge ACLK);
         #2;
         k++;
      end
      check("p6_reached_beat4", sb_beat, 4);
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      check("p6_reset_wvalid", bus.M_AXI_WVALID, 1'b0);
      check("p6_reset_awvalid", bus.M_AXI_AWVALID, 1'b0);
      check("p6_reset_burst_count", burst_count, 32'd0);
      ARESET = 1'b0;
      repeat (20) @(negedge ACLK);
      check("p6_fifo_empty_no_burst", bus.M_AXI_AWVALID, 1'b0);
      feed(8, 100);
      wait_bc(32'd1, 100);
      check("p6_wr_ptr", wr_ptr, 32'h0000_3020);

      repeat (5) @(negedge ACLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/acoustic_burst_writer.md
Name: acoustic_burst_writer

Overview:
AXI4 burst master that packs the hydrophone ADC sample stream into fixed 8-beat INCR write bursts to a circular capture buffer. It sits directly upstream of the AXI4 full slave memory IP. Its bursts have exactly the shape that slave accepts: ID 0, 32-bit beats, length 8.
- Free-running input: the ADC is never stalled.
- If the internal FIFO fills, samples are dropped and the drop is flagged.

Parameters:
ADDR_WIDTH, 32, AXI address width
FIFO_DEPTH, 16, sample FIFO entries; power of two, >= 2*BURST_BEATS
BURST_BEATS, 8, beats per burst; fixed, AWLEN = BURST_BEATS-1 = 7
BUF_BYTES, 4096, capture buffer size in bytes; multiple of 32

Ports:
ACLK  in  1  sole clock, rising edge
ARESET  in  1  synchronous, active-high reset
enable  in  1  1 = capture and write; 0 = stop issuing new bursts
base_addr  in  ADDR_WIDTH  buffer base, 32-byte aligned, sampled when leaving IDLE after reset/disable
s_tdata  in  32  ADC sample
s_tvalid  in  1  sample valid; always accepted
M_AXI_AWADDR  out  ADDR_WIDTH  burst address
M_AXI_AWLEN  out  8  constant 7
M_AXI_AWSIZE  out  3  constant 3'b010
M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  32
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WLAST  out  1
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
burst_count  out  32  completed bursts; wraps at 2^32
wr_ptr  out  ADDR_WIDTH  address of the next burst to issue
overflow  out  1  sticky; a sample was dropped
bresp_err  out  1  sticky; BRESP != OKAY seen

Behaviour:
- Reset (ARESET=1 on a clock edge):
  - all VALIDs, BREADY, WLAST, overflow, bresp_err and burst_count go to 0.
  - FIFO is emptied; state = IDLE.
  - wr_ptr and AWADDR are loaded with base_addr.
  - Reset mid-burst abandons the transaction immediately; no completion of the partial burst.
- FIFO:
  - Write when s_tvalid=1 and the FIFO is not full.
  - s_tvalid=1 while full: the sample is discarded and overflow is set to 1 on the next cycle.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and no overflow occurs.
  - Occupancy counter is width clog2(FIFO_DEPTH)+1.
- State machine: IDLE -> ADDR -> DATA -> RESP -> IDLE.
  - IDLE: if enable=1 and occupancy >= 8, drive AWADDR = wr_ptr and AWVALID=1, then go to ADDR. Otherwise stay. If enable=0, wr_ptr reloads base_addr.
  - ADDR: hold AWVALID and AWADDR stable until AWREADY. On the handshake, AWVALID=0 next cycle, go to DATA, and present beat 0 with WVALID=1.
  - DATA: beat counter 0..7.
    - WDATA = FIFO head; it is popped only on WVALID&&WREADY.
    - WVALID stays asserted through the whole burst; the 8 words are already buffered, so there are no gaps.
    - WLAST=1 exactly on beat 7.
    - Handshake on beat 7: WVALID=0 and BREADY=1 next cycle, go to RESP.
  - RESP: wait for BVALID.
    - On BVALID&&BREADY: BREADY=0, burst_count += 1.
    - If BRESP != 2'b00, set bresp_err.
    - wr_ptr += 32; if the result equals base_addr+BUF_BYTES, wr_ptr = base_addr.
    - Go to IDLE.
- Only one outstanding transaction at a time. The AW and W phases never overlap.
- enable deasserted mid-burst: the current burst completes through RESP; no new burst starts.
- Minimum latency: 8th sample accepted -> AWVALID is 1 cycle; back-to-back bursts have 1 IDLE cycle between them.
- AXI compliance: VALID never depends combinationally on READY. Payload stays stable while VALID=1 and READY=0.

Test Plan:
- Reset then enable=1, base_addr=0x0000_0000; feed samples 1..8 with an always-ready slave -> one burst: AWADDR=0, AWLEN=7, WDATA 1..8, WLAST on beat 8; burst_count=1, wr_ptr=0x20.
- Feed 128 samples into BUF_BYTES=4096 with base 0x1000 -> 16 bursts at 0x1000..0x11E0; burst_count=16; memory reads back 1..128.
- Stream 1024 samples, base 0x1000 -> the 128th burst lands at 0x1FE0, the 129th at 0x1000 (wrap); bursts are strictly ascending otherwise.
- Slave holds AWREADY=0 for 20 cycles and toggles WREADY randomly while s_tvalid=1 every cycle -> AWADDR/WDATA stable under stall; overflow=1 after the FIFO fills past 16 entries; no beat duplicated or skipped among accepted samples.
- Slave returns BRESP=2'b10 on burst 2 -> bresp_err=1 and stays 1; burst_count still increments; capture continues.
- Assert ARESET during beat 4 of a burst -> next cycle WVALID=0, AWVALID=0, FIFO empty, burst_count=0; after release, the first burst goes to base_addr.
